// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants, fetch states and helpers for the IF fetch engine.
package if_fetch_unit_pkg;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
   localparam logic [31:0] ADEL_FINAL = 32'h0000_0004;
   localparam logic        STOP       = 1'b1;
   localparam logic        NO_STOP    = 1'b0;

   typedef enum logic [1:0] {
      IF_REQ  = 2'd0,
      IF_WAIT = 2'd1,
      IF_HOLD = 2'd2
   } if_state_e;

   function automatic logic [31:0] word_addr(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage fetch engine with one outstanding SRAM-style fetch, delay slots and flush redirect.
// Define IF_ADEL_CHECK_EN to turn misaligned fetch PCs into an AdEL delivery instead of a bus request.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   output logic        stallreq_from_if,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o,
   output logic [31:0] excepttype_o
);
   if_state_e   state, state_n;
   logic [31:0] fetch_pc, pc_n, redir_pc, redir_n, br_tgt, br_tgt_n, inst_buf, buf_n, next_pc;
   logic        discard, discard_n, br_pend, br_pend_n;
   logic        mis, mis_req, accepted, data_ret, br_now, consume, unused;

`ifdef IF_ADEL_CHECK_EN
   logic adel, adel_n;
   assign mis = |fetch_pc[1:0];
   assign adel_n = state == IF_HOLD ? adel : mis;
   assign excepttype_o = inst_valid_o && adel ? ADEL_FINAL : ZERO_WORD;
   always_ff @(posedge clk) adel <= rst ? 1'b0 : adel_n;
`else
   assign mis = 1'b0;
   assign excepttype_o = ZERO_WORD;
`endif

   assign mis_req = state == IF_REQ && mis;
   assign inst_req = !rst && state == IF_REQ && !mis;
   assign inst_addr = inst_req ? word_addr(fetch_pc) : ZERO_WORD;
   assign inst_valid_o = !rst && !flush && state == IF_HOLD;
   assign pc_o = inst_valid_o ? fetch_pc : ZERO_WORD;
   assign inst_o = inst_valid_o ? inst_buf : ZERO_WORD;
   assign stallreq_from_if = (!rst && !flush && state != IF_HOLD) ? STOP : NO_STOP;
   assign accepted = inst_req && inst_addr_ok;
   assign data_ret = state == IF_WAIT ? inst_data_ok : accepted && inst_data_ok;
   assign br_now = branch_flag_i && !stall[2];
   assign consume = state == IF_HOLD && !stall[1];
   // a branch resolving in the very cycle its delay slot is consumed is bypassed straight in
   assign next_pc = br_now ? branch_target_i : br_pend ? br_tgt : fetch_pc + 32'd4;
   assign unused = ^{stall[5:3], stall[0]};

   always_comb begin
      state_n = state;
      pc_n = fetch_pc;
      redir_n = flush ? new_pc : redir_pc;
      discard_n = discard;
      br_pend_n = !flush && !consume && (br_now || br_pend);
      br_tgt_n = br_now ? branch_target_i : br_tgt;
      buf_n = data_ret ? inst_rdata : inst_buf;
      if (data_ret) begin
         state_n = discard || flush ? IF_REQ : IF_HOLD;
         pc_n = flush ? new_pc : discard ? redir_pc : fetch_pc;
         discard_n = 1'b0;
      end else if (flush) begin
         state_n = state == IF_HOLD || mis_req ? IF_REQ : accepted ? IF_WAIT : state;
         pc_n = state == IF_HOLD || mis_req ? new_pc : fetch_pc;
         discard_n = !(state == IF_HOLD || mis_req);
      end else if (accepted) begin
         state_n = IF_WAIT;
      end else if (mis_req) begin
         state_n = IF_HOLD;
         buf_n = ZERO_WORD;
      end else if (consume) begin
         state_n = IF_REQ;
         pc_n = next_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IF_REQ;
         fetch_pc <= RESET_PC;
         redir_pc <= RESET_PC;
         br_tgt <= ZERO_WORD;
         inst_buf <= ZERO_WORD;
         discard <= 1'b0;
         br_pend <= 1'b0;
      end else begin
         state <= state_n;
         fetch_pc <= pc_n;
         redir_pc <= redir_n;
         br_tgt <= br_tgt_n;
         inst_buf <= buf_n;
         discard <= discard_n;
         br_pend <= br_pend_n;
      end
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus with a transaction-level fetch model checked every cycle.
module tb_if_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef IF_ADEL_CHECK_EN
   localparam bit ADEL = 1'b1;
`else
   localparam bit ADEL = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, branch_flag_i = 1'b0;
   logic [5:0]  stall = '0;
   logic [31:0] new_pc = '0, branch_target_i = '0, inst_rdata = '0;
   logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
   logic        stallreq_from_if, inst_req, inst_valid_o;
   logic [31:0] inst_addr, pc_o, inst_o, excepttype_o;
   int          n_chk = 0, n_pass = 0;

   if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
      .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
      .stallreq_from_if(stallreq_from_if), .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o), .excepttype_o(excepttype_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", n, act, exp);
   endtask

   // model: next fresh fetch address, one outstanding slot, held request, pending branch, delivered word
   logic [31:0] exp_fetch, held_pc, ob_pc, pend_tgt, dv_pc, dv_inst;
   logic        ob, ob_doom, doom_next, held, pend, dv, dv_adel;

   always @(negedge clk) begin
      logic        mis, exp_req, adel_go;
      logic [31:0] cur;
      if (rst) begin
         chk("rst_req", {31'b0, inst_req}, 32'd0);
         chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
         chk("rst_stallreq", {31'b0, stallreq_from_if}, 32'd0);
         exp_fetch = RESET_PC;
         ob = 0; ob_doom = 0; doom_next = 0; held = 0; pend = 0; dv = 0; dv_adel = 0;
      end else begin
         mis = ADEL && exp_fetch[1:0] != 2'b00;
         cur = held ? held_pc : exp_fetch;
         exp_req = !dv && !ob && (held || !mis);
         chk("req", {31'b0, inst_req}, {31'b0, exp_req});
         if (inst_req) chk("req_addr", inst_addr, {cur[31:2], 2'b00});
         chk("valid", {31'b0, inst_valid_o}, {31'b0, dv && !flush});
         if (dv && !flush) begin
            chk("pc_o", pc_o, dv_pc);
            chk("inst_o", inst_o, dv_inst);
            chk("excepttype", excepttype_o, dv_adel ? 32'h4 : 32'h0);
         end
         chk("stallreq", {31'b0, stallreq_from_if}, {31'b0, !flush && !dv});
         adel_go = mis && !dv && !ob && !held && !flush;
         if (inst_req && inst_addr_ok) begin
            ob = 1; ob_pc = cur; ob_doom = doom_next; doom_next = 0;
         end
         held = inst_req && !inst_addr_ok;
         held_pc = cur;
         if (branch_flag_i && !stall[2] && !flush) begin
            pend = 1; pend_tgt = branch_target_i;
         end
         if (dv && !flush && !stall[1]) begin
            dv = 0; exp_fetch = pend ? pend_tgt : dv_pc + 32'd4; pend = 0;
         end
         if (flush) begin
            pend = 0; dv = 0; exp_fetch = new_pc; ob_doom = 1;
            if (held) doom_next = 1;
         end
         if (inst_data_ok && ob) begin
            ob = 0;
            if (!ob_doom) begin
               dv = 1; dv_pc = ob_pc; dv_inst = inst_rdata; dv_adel = 0;
            end
         end else if (adel_go) begin
            dv = 1; dv_pc = exp_fetch; dv_inst = 32'h0; dv_adel = 1;
         end
      end
   end

   task automatic tick(input logic ao, input logic dok, input logic [31:0] rd);
      inst_addr_ok = ao; inst_data_ok = dok; inst_rdata = rd;
      @(posedge clk);
      #1;
      inst_addr_ok = 0; inst_data_ok = 0; flush = 0; branch_flag_i = 0;
      #1;
   endtask

   task automatic fetch(input logic [31:0] rd);
      for (int k = 0; k < 10 && !inst_req; k++) tick(0, 0, 0);
      chk("fetch_req_seen", {31'b0, inst_req}, 32'd1);
      tick(1, 0, 0);
      tick(0, 1, rd);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 0;
      #1;
      chk("t1_req", {31'b0, inst_req}, 32'd1);
      chk("t1_addr", inst_addr, 32'hBFC0_0000);
      chk("t1_stallreq", {31'b0, stallreq_from_if}, 32'd1);
      tick(1, 0, 0);
      chk("t2_wait_noreq", {31'b0, inst_req}, 32'd0);
      tick(0, 1, 32'h2402_0001);
      chk("t2_inst", inst_o, 32'h2402_0001);
      chk("t2_pc", pc_o, 32'hBFC0_0000);
      chk("t2_stallreq", {31'b0, stallreq_from_if}, 32'd0);
      tick(0, 0, 0);
      chk("t2_next_addr", inst_addr, 32'hBFC0_0004);
      stall = 6'b000010;
      fetch(32'h8C43_0000);
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 0);
         chk("t3_hold_inst", inst_o, 32'h8C43_0000);
         chk("t3_hold_pc", pc_o, 32'hBFC0_0004);
         chk("t3_hold_noreq", {31'b0, inst_req}, 32'd0);
      end
      stall = 6'b0;
      tick(0, 0, 0);
      chk("t3_next_addr", inst_addr, 32'hBFC0_0008);
      tick(1, 0, 0);
      flush = 1; new_pc = 32'hBFC0_0380;
      tick(0, 0, 0);
      tick(0, 1, 32'hDEAD_BEEF);
      chk("t4_dropped", {31'b0, inst_valid_o}, 32'd0);
      chk("t4_redirect", inst_addr, 32'hBFC0_0380);
      flush = 1; new_pc = 32'h0000_0F00;
      tick(0, 0, 0);
      chk("t4_held_addr", inst_addr, 32'hBFC0_0380);
      flush = 1; new_pc = 32'h0000_0100;
      tick(0, 0, 0);
      tick(1, 0, 0);
      tick(0, 1, 32'hBAD0_BAD0);
      chk("t4_second_flush", inst_addr, 32'h0000_0100);
      fetch(32'h1000_0003);
      tick(0, 0, 0);
      branch_flag_i = 1; branch_target_i = 32'h0000_0200;
      tick(1, 0, 0);
      tick(0, 1, 32'h0000_0000);
      chk("t5_delay_slot", pc_o, 32'h0000_0104);
      tick(0, 0, 0);
      chk("t5_target", inst_addr, 32'h0000_0200);
      stall = 6'b000100; branch_flag_i = 1; branch_target_i = 32'h0000_0300;
      tick(1, 0, 0);
      stall = 6'b0;
      tick(0, 1, 32'h3C01_0000);
      chk("t5_target_pc", pc_o, 32'h0000_0200);
      tick(0, 0, 0);
      chk("t5_id_stall_no_branch", inst_addr, 32'h0000_0204);
      tick(1, 1, 32'h1111_1111);
      chk("same_cycle_pc", pc_o, 32'h0000_0204);
      flush = 1; new_pc = 32'hFFFF_FFFC;
      #1;
      chk("flush_kills_valid", {31'b0, inst_valid_o}, 32'd0);
      tick(0, 0, 0);
      chk("wrap_start", inst_addr, 32'hFFFF_FFFC);
      fetch(32'h2222_2222);
      tick(0, 0, 0);
      chk("wrap_next", inst_addr, 32'h0000_0000);
      stall = 6'b000010;
      fetch(32'h4444_4444);
      flush = 1; new_pc = 32'hBFC0_0382;
      tick(0, 0, 0);
`ifdef IF_ADEL_CHECK_EN
      chk("t6_noreq", {31'b0, inst_req}, 32'd0);
      tick(0, 0, 0);
      chk("t6_pc", pc_o, 32'hBFC0_0382);
      chk("t6_exc", excepttype_o, 32'h0000_0004);
      chk("t6_inst", inst_o, 32'h0);
`else
      chk("t6_addr_forced", inst_addr, 32'hBFC0_0380);
      fetch(32'h3333_3333);
      chk("t6_pc", pc_o, 32'hBFC0_0382);
      chk("t6_exc", excepttype_o, 32'h0);
`endif
      flush = 1; new_pc = 32'hBFC0_0000;
      tick(0, 0, 0);
      stall = 6'b0;
      tick(1, 0, 0);
      rst = 1;
      tick(0, 0, 0);
      rst = 0;
      #1;
      chk("rst_mid_addr", inst_addr, 32'hBFC0_0000);
      tick(0, 1, 32'h7777_7777);
      chk("late_data_ignored", {31'b0, inst_valid_o}, 32'd0);
      chk("late_data_req", inst_addr, 32'hBFC0_0000);
      fetch(32'h5555_5555);
      chk("after_rst_inst", inst_o, 32'h5555_5555);
      tick(0, 0, 0);
      tick(0, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
